// File: rtl/decoded_word_unpack_stage.sv
// -----------------------------------------------------------------------------
// decoded_word_unpack_stage
//
// Receiver side of the packed decoded-instruction word at the ID/EX boundary.
// A word arrives over a valid/ready handshake and goes into a two-entry skid
// pair (main M, skid S). M is always the head, and its fields drive the
// execute stage directly as registered outputs. flush discards both entries.
// A saturating counter records the cycles in which execute back-pressured a
// valid word.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop all buffered words (mispredict / exception)
//   in_valid, in_ready  upstream handshake (in_ready has no path from
//                       in_valid or out_ready)
//   in_word             packed decoded word
//   out_valid,out_ready downstream handshake, out_valid = M holds a word
//   use_* / read_mem / write_mem / decoded_opcode / inst_type /
//   rs1_addr / rs2_addr / rd_addr / imm / value / npc
//                       field slices of the M word
//   stall_count         saturating count of out_valid & !out_ready cycles
// -----------------------------------------------------------------------------

// Default field layout of the decoded word. Any definition made earlier by the
// architecture header takes precedence.
`ifndef DECODED_INST_WORD_WIDTH
  `define DECODED_INST_WORD_WIDTH 112
`endif
`ifndef OPCODE_WIDTH
  `define OPCODE_WIDTH            7
`endif
`ifndef INST_TYPE_SIGNAL_WIDTH
  `define INST_TYPE_SIGNAL_WIDTH  4
`endif
`ifndef REG_ADDR_SIZE
  `define REG_ADDR_SIZE           5
`endif
`ifndef IMM_WIDTH
  `define IMM_WIDTH               16
`endif
`ifndef VALUE_WIDTH
  `define VALUE_WIDTH             32
`endif
`ifndef PC_WIDTH
  `define PC_WIDTH                32
`endif
`ifndef USE_RS1_START_BIT
  `define USE_RS1_START_BIT       0
  `define USE_RS2_START_BIT       1
  `define USE_RD_START_BIT        2
  `define USE_IMM_START_BIT       3
  `define READ_MEM_START_BIT      4
  `define WRITE_MEM_START_BIT     5
  `define OPCODE_START_BIT        6
  `define OPCODE_END_BIT          12
  `define INST_TYPE_START_BIT     13
  `define INST_TYPE_END_BIT       16
  `define RS1_ADDR_START_BIT      17
  `define RS1_ADDR_END_BIT        21
  `define RS2_ADDR_START_BIT      22
  `define RS2_ADDR_END_BIT        26
  `define RD_ADDR_START_BIT       27
  `define RD_ADDR_END_BIT         31
  `define IMM_START_BIT           32
  `define IMM_END_BIT             47
  `define VALUE_START_BIT         48
  `define VALUE_END_BIT           79
  `define NPC_START_BIT           80
  `define NPC_END_BIT             111
`endif

module decoded_word_unpack_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [`DECODED_INST_WORD_WIDTH-1:0]   in_word,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  use_rs1,
    output logic                                  use_rs2,
    output logic                                  use_rd,
    output logic                                  use_imm,
    output logic                                  read_mem,
    output logic                                  write_mem,
    output logic [`OPCODE_WIDTH-1:0]              decoded_opcode,
    output logic [`INST_TYPE_SIGNAL_WIDTH-1:0]    inst_type,
    output logic [`REG_ADDR_SIZE-1:0]             rs1_addr,
    output logic [`REG_ADDR_SIZE-1:0]             rs2_addr,
    output logic [`REG_ADDR_SIZE-1:0]             rd_addr,
    output logic [`IMM_WIDTH-1:0]                 imm,
    output logic [`VALUE_WIDTH-1:0]               value,
    output logic [`PC_WIDTH-1:0]                  npc,
    output logic [STALL_CNT_W-1:0]                stall_count
);

    localparam int W = `DECODED_INST_WORD_WIDTH;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

    logic         m_valid;
    logic         s_valid;
    logic [W-1:0] m_word;
    logic [W-1:0] s_word;
    logic         acc;
    logic         pop;

    // S only ever fills while M is occupied, so an empty S guarantees a free
    // slot somewhere regardless of what downstream does this cycle.
    assign in_ready  = !rst && !flush && !s_valid;
    assign out_valid = m_valid;
    assign acc       = in_valid && in_ready;
    assign pop       = m_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below sees the pre-edge values of m_valid/s_valid/m_word/s_word.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data words are reset (not just the valid bits) because
            // the field outputs are required to read zero after reset/flush.
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_word  <= '0;
            s_word  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_word  <= '0;
            s_word  <= '0;
        end else if (!m_valid) begin
            if (acc) begin
                m_word  <= in_word;
                m_valid <= 1'b1;
            end
        end else if (pop && s_valid) begin
            // in_ready is low while S is full, so no new word competes here.
            m_word  <= s_word;
            s_valid <= 1'b0;
        end else if (pop) begin
            if (acc) begin
                m_word <= in_word;
            end else begin
                // m_word keeps the drained word so the fields stay steady.
                m_valid <= 1'b0;
            end
        end else if (acc) begin
            s_word  <= in_word;
            s_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (m_valid && !out_ready && !flush && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_ONE;
        end
    end

    assign use_rs1        = m_word[`USE_RS1_START_BIT];
    assign use_rs2        = m_word[`USE_RS2_START_BIT];
    assign use_rd         = m_word[`USE_RD_START_BIT];
    assign use_imm        = m_word[`USE_IMM_START_BIT];
    assign read_mem       = m_word[`READ_MEM_START_BIT];
    assign write_mem      = m_word[`WRITE_MEM_START_BIT];
    assign decoded_opcode = m_word[`OPCODE_END_BIT:`OPCODE_START_BIT];
    assign inst_type      = m_word[`INST_TYPE_END_BIT:`INST_TYPE_START_BIT];
    assign rs1_addr       = m_word[`RS1_ADDR_END_BIT:`RS1_ADDR_START_BIT];
    assign rs2_addr       = m_word[`RS2_ADDR_END_BIT:`RS2_ADDR_START_BIT];
    assign rd_addr        = m_word[`RD_ADDR_END_BIT:`RD_ADDR_START_BIT];
    assign imm            = m_word[`IMM_END_BIT:`IMM_START_BIT];
    assign value          = m_word[`VALUE_END_BIT:`VALUE_START_BIT];
    assign npc            = m_word[`NPC_END_BIT:`NPC_START_BIT];

endmodule
